uart_transmitter: RTL and testbench

//   UART serial transmitter. Pairs with the UART receiver on the same 16x-oversampled baud_tick.

---
 rtl/uart_transmitter_pkg.sv | 21 ++
 rtl/uart_transmitter_if.sv | 27 ++
 rtl/uart_transmitter.sv | 137 +++++++++++++
 tb/tb_uart_transmitter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// rtl/uart_transmitter_pkg.sv - shared UART state encodings and defaults
package uart_transmitter_pkg;

   // Frame sequencing states, shared with the receiver side
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   // Tick counter must reach 2*OVERSAMPLE-1 to time two stop bits as one span
   function automatic int tick_cnt_width(input int oversample);
      return $clog2(oversample * 2);
   endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - parallel-word handshake between host logic and the transmitter
interface uart_transmitter_if
   import uart_transmitter_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
);
   logic                 tx_start;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_busy;
   logic                 tx_done;

   // Host side issues words and watches completion
   modport master (
      output tx_start,
      output tx_data,
      input  tx_busy,
      input  tx_done
   );

   // Transmitter side accepts words and reports progress
   modport slave (
      input  tx_start,
      input  tx_data,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serial transmitter on a shared oversampled baud tick
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              baud_tick,
   uart_transmitter_if.slave tx_if,
   output logic              tx
);
   localparam int TW = tick_cnt_width(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic PAR_INIT = (PARITY_ODD != 0);
   localparam logic HAS_PAR  = (PARITY_EN != 0);

   tx_state_t            r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_parity;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_done;

   logic w_tick_last;
   logic w_bit_end;

   assign tx            = r_tx;
   assign tx_if.tx_busy = r_busy;
   assign tx_if.tx_done = r_done;

   // The stop span covers all stop bits at once; every other state lasts one bit
   always_comb begin
      w_tick_last = 1'b0;
      if (r_state == ST_STOP) begin
         w_tick_last = (r_tick_cnt == STOP_LAST);
      end else begin
         w_tick_last = (r_tick_cnt == BIT_LAST);
      end
      w_bit_end = baud_tick && w_tick_last;
   end

   // Frame sequencer, shifter, counters and registered line/status outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if ((r_state != ST_IDLE) && baud_tick) begin
            r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (tx_if.tx_start) begin
                  r_shift    <= tx_if.tx_data;
                  r_parity   <= PAR_INIT;
                  r_tick_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_START;
               end
            end

            ST_START: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (w_bit_end) begin
                  r_parity <= r_parity ^ r_shift[0];
                  r_shift  <= r_shift >> 1;
                  if (r_bit_cnt == DATA_LAST) begin
                     if (HAS_PAR) begin
                        r_tx    <= r_parity ^ r_shift[0];
                        r_state <= ST_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_tx      <= r_shift[1];
                  end
               end
            end

            ST_PARITY: begin
               if (w_bit_end) begin
                  r_tx    <= 1'b1;
                  r_state <= ST_STOP;
               end
            end

            ST_STOP: begin
               if (w_bit_end) begin
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter in three configurations
module tb_uart_transmitter;

   logic clk = 1'b0;
   logic rstn;
   logic baud_tick;
   logic tick_en;
   int   tick_div;

   logic       st  [3];
   logic [7:0] dat [3];
   logic       tx0, tx1, tx2;
   logic       w_tx [3];
   logic       busy [3];
   logic       done [3];

   int cfg_db  [3] = '{8, 8, 5};
   int cfg_pen [3] = '{0, 1, 1};
   int cfg_pod [3] = '{0, 0, 1};
   int cfg_sb  [3] = '{1, 2, 1};

   int checks = 0;
   int errors = 0;

   logic [15:0] q0[$], q1[$], q2[$];

   bit          in_frame [3];
   int          ticks    [3];
   int          mism     [3];
   logic [15:0] cur_exp  [3];
   logic [15:0] cap      [3];

   always #5 clk = ~clk;

   uart_transmitter_if #(.DATA_BITS(8)) if0 ();
   uart_transmitter_if #(.DATA_BITS(8)) if1 ();
   uart_transmitter_if #(.DATA_BITS(5)) if2 ();

   assign if0.tx_start = st[0];
   assign if1.tx_start = st[1];
   assign if2.tx_start = st[2];
   assign if0.tx_data  = dat[0];
   assign if1.tx_data  = dat[1];
   assign if2.tx_data  = dat[2][4:0];
   assign w_tx[0] = tx0;
   assign w_tx[1] = tx1;
   assign w_tx[2] = tx2;
   assign busy[0] = if0.tx_busy;
   assign busy[1] = if1.tx_busy;
   assign busy[2] = if2.tx_busy;
   assign done[0] = if0.tx_done;
   assign done[1] = if1.tx_done;
   assign done[2] = if2.tx_done;

   uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16))
      dut0 (.clk(clk), .rstn(rstn), .baud_tick(baud_tick), .tx_if(if0), .tx(tx0));
   uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .OVERSAMPLE(16))
      dut1 (.clk(clk), .rstn(rstn), .baud_tick(baud_tick), .tx_if(if1), .tx(tx1));
   uart_transmitter #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .OVERSAMPLE(16))
      dut2 (.clk(clk), .rstn(rstn), .baud_tick(baud_tick), .tx_if(if2), .tx(tx2));

   // Reference frame: start 0, data LSB-first, optional parity, stop 1s; bit i is line bit i
   function automatic logic [15:0] exp_frame(input int k, input logic [7:0] d);
      logic [15:0] f;
      logic        par;
      int          p;
      f   = '0;
      p   = 1;
      par = (cfg_pod[k] != 0);
      for (int i = 0; i < cfg_db[k]; i++) begin
         f[p] = d[i];
         par  = par ^ d[i];
         p++;
      end
      if (cfg_pen[k] != 0) begin
         f[p] = par;
         p++;
      end
      for (int i = 0; i < cfg_sb[k]; i++) begin
         f[p] = 1'b1;
         p++;
      end
      return f;
   endfunction

   function automatic int frame_bits(input int k);
      return 1 + cfg_db[k] + cfg_pen[k] + cfg_sb[k];
   endfunction

   task automatic push_exp(input int k, input logic [15:0] f);
      case (k)
         0:       q0.push_back(f);
         1:       q1.push_back(f);
         default: q2.push_back(f);
      endcase
   endtask

   task automatic pop_exp(input int k, output logic [15:0] f, output bit ok);
      ok = 1'b1;
      f  = '0;
      case (k)
         0:       if (q0.size() == 0) ok = 1'b0; else f = q0.pop_front();
         1:       if (q1.size() == 0) ok = 1'b0; else f = q1.pop_front();
         default: if (q2.size() == 0) ok = 1'b0; else f = q2.pop_front();
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   // Baud generator: one tick every third clk, gated for the stall test
   initial begin
      baud_tick = 1'b0;
      tick_div  = 0;
      forever begin
         @(negedge clk);
         tick_div  = (tick_div == 2) ? 0 : tick_div + 1;
         baud_tick = tick_en && (tick_div == 0);
      end
   end

   // Monitor: follows each frame in baud ticks and compares against the popped expectation
   task automatic mon_step(input int k);
      bit          ended;
      bit          ok;
      int          idx;
      logic [15:0] f;
      ended = 1'b0;
      if (!rstn) begin
         in_frame[k] = 1'b0;
         return;
      end
      if (in_frame[k]) begin
         if (baud_tick) ticks[k]++;
         if (busy[k]) begin
            idx = ticks[k] / 16;
            if (idx < frame_bits(k)) begin
               cap[k][idx] = w_tx[k];
               if (w_tx[k] !== cur_exp[k][idx]) mism[k]++;
            end else begin
               mism[k]++;
            end
         end else begin
            ended       = 1'b1;
            in_frame[k] = 1'b0;
            checks++;
            if ((cap[k] !== cur_exp[k]) || (mism[k] != 0)) begin
               errors++;
               $display("FAIL frame_bits k=%0d actual=%h required=%h bad_cycles=%0d", k, cap[k], cur_exp[k], mism[k]);
            end
            checks++;
            if (ticks[k] != frame_bits(k) * 16) begin
               errors++;
               $display("FAIL frame_len k=%0d actual=%0d ticks required=%0d ticks", k, ticks[k], frame_bits(k) * 16);
            end
            checks++;
            if (done[k] !== 1'b1) begin
               errors++;
               $display("FAIL done_pulse k=%0d actual=%b required=1", k, done[k]);
            end
         end
      end else if (busy[k]) begin
         in_frame[k] = 1'b1;
         ticks[k]    = 0;
         mism[k]     = 0;
         cap[k]      = '0;
         pop_exp(k, f, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL unexpected_frame k=%0d actual=frame_started required=no_frame", k);
            f = exp_frame(k, 8'h00);
         end
         cur_exp[k] = f;
         cap[k][0]  = w_tx[k];
         if (w_tx[k] !== f[0]) mism[k]++;
      end
      if (!ended && (done[k] === 1'b1)) begin
         checks++;
         errors++;
         $display("FAIL spurious_done k=%0d actual=1 required=0", k);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) mon_step(k);
   end

   // Waits for busy to reach a level; n is cycles taken, or a FAIL on timeout
   task automatic wait_busy(input int k, input logic val, input int max, output int n);
      n = -1;
      for (int i = 0; i < max; i++) begin
         @(posedge clk);
         #1;
         if (busy[k] === val) begin
            n = i + 1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL wait_busy k=%0d actual=timeout required=busy_%b", k, val);
   endtask

   task automatic send(input int k, input logic [7:0] d);
      int n;
      wait_busy(k, 1'b0, 3000, n);
      st[k]  = 1'b1;
      dat[k] = d;
      push_exp(k, exp_frame(k, d));
      @(posedge clk);
      #1;
      st[k]  = 1'b0;
      dat[k] = 8'($urandom);
   endtask

   task automatic finish_all();
      int n;
      for (int k = 0; k < 3; k++) wait_busy(k, 1'b0, 3000, n);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [7:0] words [4];
      words = '{8'h00, 8'hFF, 8'h55, 8'h3C};
      rstn    = 1'b0;
      tick_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         st[k]  = 1'b0;
         dat[k] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (w_tx[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state k=%0d actual tx=%b busy=%b done=%b required tx=1 busy=0 done=0", k, w_tx[k], busy[k], done[k]);
         end
      end
      rstn = 1'b1;

      // 8N1 single frame
      send(0, 8'hA5);
      finish_all();

      // back-to-back with start held; one idle clk between frames
      st[0]  = 1'b1;
      dat[0] = words[0];
      push_exp(0, exp_frame(0, words[0]));
      for (int i = 0; i < 4; i++) begin
         wait_busy(0, 1'b1, 3000, n);
         checks++;
         if (n != 1) begin
            errors++;
            $display("FAIL accept_gap i=%0d actual=%0d clks required=1 clks", i, n);
         end
         if (i < 3) begin
            dat[0] = words[i + 1];
            push_exp(0, exp_frame(0, words[i + 1]));
            wait_busy(0, 1'b0, 3000, n);
         end else begin
            st[0] = 1'b0;
         end
      end
      finish_all();

      // parity, even/2 stop and odd/5 data bits
      send(1, 8'h07);
      send(2, 8'h07);
      finish_all();

      // start pulse during an active frame is ignored
      send(0, 8'h34);
      repeat (200) @(posedge clk);
      #1;
      st[0]  = 1'b1;
      dat[0] = 8'h12;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      finish_all();
      repeat (200) @(posedge clk);
      #1;
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL ignored_start actual busy=%b required busy=0", busy[0]);
      end

      // async reset mid-DATA, then a clean frame
      send(0, 8'h81);
      repeat (150) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (tx0 !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset actual tx=%b busy=%b required tx=1 busy=0", tx0, busy[0]);
      end
      repeat (2) @(posedge clk);
      #3;
      rstn = 1'b1;
      send(0, 8'h81);
      finish_all();

      // baud ticks stalled during the start bit
      send(0, 8'hC3);
      tick_en = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (tx0 !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL tick_stall actual tx=%b busy=%b required tx=0 busy=1", tx0, busy[0]);
      end
      tick_en = 1'b1;
      finish_all();

      // randomized words across all configurations
      for (int i = 0; i < 20; i++) begin
         send($urandom_range(0, 2), 8'($urandom));
         repeat ($urandom_range(0, 30)) @(posedge clk);
         #1;
      end
      finish_all();

      for (int k = 0; k < 3; k++) begin
         checks++;
         if (q_size(k) != 0) begin
            errors++;
            $display("FAIL leftover_expect k=%0d actual=%0d required=0", k, q_size(k));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
